seq_frame_tx: RTL and testbench
===============================

# seq_frame_tx

Serial frame transmitter producing the bitstream our serial sequence detectors consume. It accepts a parallel data word over a valid/ready handshake. It then emits, one bit per clock, the fixed 5-bit sync pattern 10010 followed by the data word MSB first. It sits upstream of the detector, and its `sout` drives the detector's serial input directly.

## Interface
- `DATA_W`, 8: payload width in bits; legal range 1–32.
- `SYNC`, 5'b10010: sync pattern, sent MSB first; its width is fixed at 5.
- `Clock`  input  1  single clock; all state changes on the rising edge.
- `Reset`  input  1  reset is synchronous and active-high, sampled on the rising edge of `Clock`.
- `din`  input  DATA_W  payload word; sampled only on an accepted handshake.
- `din_valid`  input  1  producer has a word on `din`.
- `din_ready`  output  1  block can accept a word; registered.
- `sout`  output  1  serial bit out; registered.
- `sout_en`  output  1  high while `sout` carries a frame bit; registered.
- `frame_done`  output  1  one-cycle pulse marking the last bit of a frame; registered.

## Operation
- FSM states: IDLE, SYNC, DATA, and PAR (PAR exists only with the parity macro).
- Frame length L = 5 + DATA_W, plus 1 when parity is compiled in.
- IDLE:
  - Outputs: `din_ready`=1, `sout`=0, `sout_en`=0.
  - Accept condition: `din_valid`&&`din_ready` at an edge.
  - On accept: latch `din` into the shift register, go to SYNC with bit count 0, drop `din_ready`.
- SYNC:
  - `sout` = `SYNC`[4-count], `sout_en`=1.
  - After the 5th bit, go to DATA with the count cleared.
- DATA:
  - `sout` = latched word bit [DATA_W-1-count], i.e. MSB first.
  - After bit DATA_W, go to PAR if compiled in, else to IDLE.
- PAR: `sout` = even parity (XOR of all latched data bits), then go to IDLE.
- Outside IDLE, `din_valid` and `din` are ignored; the latched copy is the only payload source.
- `frame_done`=1 exactly during the cycle the final frame bit is on `sout`; 0 otherwise.
- The bit counter is sized ceil(log2(max(5, DATA_W)))+1 bits.
  - It counts up from 0 within each state.
  - It never wraps mid-state and is cleared on every state change.
- Reset mid-frame: the frame is aborted with no partial completion; `frame_done` is not pulsed.
- Illegal or unreachable state encodings return to IDLE on the next edge.
- Payload is not escaped: data may itself contain 10010. Downstream framing is the consumer's concern.

## Timing
- Reset values of outputs after a reset edge: `din_ready`=1, `sout`=0, `sout_en`=0, `frame_done`=0, state IDLE.
- While `Reset` is high, handshakes are ignored.
- Accept at edge k: first sync bit (1) is on `sout` after edge k, and the last frame bit is on `sout` after edge k+L-1.
- `frame_done` is high during the cycle following edge k+L-1.
- After edge k+L the block is back in IDLE: `sout`=0, `sout_en`=0, `din_ready`=1.
- Earliest next accept is edge k+L+1. Frames are therefore separated by at least one idle cycle of `sout`=0.
- With `din_valid` held high continuously, frames repeat every L+1 cycles.
- Latency from accept to first bit: 1 cycle. From accept to `frame_done`: L cycles.

## Configuration
- Macro `SEQ_FRAME_TX_PARITY_EN`.
- Defined: the PAR state exists, one even-parity bit is appended after the data LSB, and L = 6 + DATA_W.
- Undefined: there is no PAR state, the frame ends at the data LSB, and L = 5 + DATA_W.
- The macro does not change the port list.

## Test plan
- Reset, idle, no valid: after reset, `din_ready`=1, `sout`=0, `sout_en`=0, `frame_done`=0 for 20 cycles.
- Single frame, DATA_W=8, `din`=8'hA5:
  - `sout` = 1,0,0,1,0, 1,0,1,0,0,1,0,1, then parity 0 if the macro is defined.
  - `sout_en` is high for exactly L cycles, and `frame_done` is high only on the last bit.
- Parity check, `din`=8'h01 (macro defined): 14-bit stream ends ...0,0,0,0,0,0,0,1,1, confirming the parity bit is 1.
- `din_valid` held high with `din` alternating 8'hFF / 8'h00:
  - Frames start every L+1 cycles, with exactly one `sout`=0 idle cycle between them.
  - Each frame carries the word present at its own accept edge.
- `din` changed and `din_valid` toggled mid-frame: output stream is unaffected and `din_ready` stays 0 until the frame ends.
- `Reset` asserted for one cycle at frame bit 7:
  - After that edge, `sout`=0, `sout_en`=0, `din_ready`=1, and `frame_done` never pulses.
  - A new accept two cycles later produces a complete, correct frame.

Source files
------------

// File: rtl/seq_frame_tx.sv
// seq_frame_tx: serial frame transmitter emitting the sync pattern followed by a latched word, MSB first.
// Ports: Clock, Reset (sync, active-high); din/din_valid/din_ready handshake accepting a DATA_W-bit word;
// sout serial bit, sout_en frame-bit qualifier, frame_done pulse on the last frame bit (all registered).
// Optional macro SEQ_FRAME_TX_PARITY_EN appends an even-parity bit after the data LSB.
module seq_frame_tx #(
  parameter int         DATA_W = 8,
  parameter logic [4:0] SYNC   = 5'b10010
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sout,
  output logic              sout_en,
  output logic              frame_done
);
  localparam int CW = $clog2(DATA_W > 5 ? DATA_W : 5) + 1;
`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;
  logic par_q, par_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
`endif
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shr_q, shr_d;
  logic              din_ready_q, din_ready_d;
  logic              sout_q, sout_d;
  logic              sout_en_q, sout_en_d;
  logic              frame_done_q, frame_done_d;
  logic              last_data;
  // state_q/cnt_q name the bit currently on sout; outputs are registered from the next-state values.
  always_comb begin
    state_d   = S_IDLE;
    cnt_d     = '0;
    shr_d     = shr_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_d     = par_q;
`endif
    last_data = cnt_q == CW'(DATA_W - 1);
    case (state_q)
      S_IDLE: if (din_valid && din_ready_q) begin
        state_d = S_SYNC;
        shr_d   = din;
`ifdef SEQ_FRAME_TX_PARITY_EN
        par_d   = ^din;
`endif
      end
      S_SYNC: begin
        state_d = cnt_q == CW'(4) ? S_DATA : S_SYNC;
        cnt_d   = cnt_q == CW'(4) ? '0 : cnt_q + CW'(1);
      end
      S_DATA: begin
`ifdef SEQ_FRAME_TX_PARITY_EN
        state_d = last_data ? S_PAR : S_DATA;
`else
        state_d = last_data ? S_IDLE : S_DATA;
`endif
        cnt_d   = last_data ? '0 : cnt_q + CW'(1);
        shr_d   = shr_q << 1;
      end
      default: state_d = S_IDLE;
    endcase
    din_ready_d  = state_d == S_IDLE;
    sout_en_d    = state_d != S_IDLE;
    sout_d       = state_d == S_SYNC ? SYNC[3'd4 - cnt_d[2:0]] :
                   state_d == S_DATA ? shr_d[DATA_W-1] : 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
    sout_d       = state_d == S_PAR ? par_d : sout_d;
    frame_done_d = state_d == S_PAR;
`else
    frame_done_d = state_d == S_DATA && cnt_d == CW'(DATA_W - 1);
`endif
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shr_q        <= '0;
      din_ready_q  <= 1'b1;
      sout_q       <= 1'b0;
      sout_en_q    <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shr_q        <= shr_d;
      din_ready_q  <= din_ready_d;
      sout_q       <= sout_d;
      sout_en_q    <= sout_en_d;
      frame_done_q <= frame_done_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end
  assign din_ready  = din_ready_q;
  assign sout       = sout_q;
  assign sout_en    = sout_en_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// tb_seq_frame_tx: randomized self-checking bench for seq_frame_tx against a frame-list model.
module tb_seq_frame_tx;
  localparam int DATA_W = 8;
`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = 5 + DATA_W + P;
  logic              Clock = 1'b0;
  logic              Reset = 1'b1;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              din_ready, sout, sout_en, frame_done;
  int                checks = 0;
  int                failures = 0;
  seq_frame_tx #(.DATA_W(DATA_W)) dut (
    .Clock(Clock), .Reset(Reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sout(sout), .sout_en(sout_en), .frame_done(frame_done)
  );
  always #5 Clock = ~Clock;
  // Expected frame as a bit list: element i is the i-th bit on sout.
  function automatic logic [63:0] model(input logic [DATA_W-1:0] w);
    logic [63:0] s = '0;
    bit sy[5] = '{1, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) s[i] = sy[i];
    for (int b = 0; b < DATA_W; b++) s[5 + b] = w[DATA_W - 1 - b];
    if (P == 1) s[5 + DATA_W] = ^w;
    return s;
  endfunction
  // Precondition: at a negedge with din/din_valid already presenting w to an idle block.
  // mode 0: drop valid after accept; 1: scramble din/valid mid-frame; 2: keep valid high, din=nxt.
  task automatic test_frame(input logic [DATA_W-1:0] w, input logic [63:0] e, input int mode,
                            input logic [DATA_W-1:0] nxt);
    logic [3:0] obs, want;
    @(posedge Clock);
    for (int i = 0; i < L; i++) begin
      @(negedge Clock);
      obs  = {din_ready, sout_en, frame_done, sout};
      want = {1'b0, 1'b1, i == L - 1, e[i]};
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL frame w=%h bit %0d {rdy,en,done,sout}: got %b want %b", w, i, obs, want);
      end
      if (mode == 1) begin
        din = DATA_W'($urandom);
        din_valid = 1'($urandom_range(0, 1));
      end else if (mode == 2) din = nxt;
      else din_valid = 1'b0;
    end
    @(negedge Clock);
    obs = {din_ready, sout_en, frame_done, sout};
    checks++;
    if (obs !== 4'b1000) begin
      failures++;
      $display("FAIL idle_after w=%h {rdy,en,done,sout}: got %b want 1000", w, obs);
    end
    if (mode != 2) din_valid = 1'b0;
  endtask
  task automatic test_reset();
    logic [3:0] obs;
    Reset = 1'b1;
    din_valid = 1'b1;
    din = DATA_W'($urandom);
    for (int i = 0; i < 23; i++) begin
      @(negedge Clock);
      if (i == 2) begin
        Reset = 1'b0;
        din_valid = 1'b0;
      end
      obs = {din_ready, sout_en, frame_done, sout};
      checks++;
      if (obs !== 4'b1000) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got %b want 1000", i, obs);
      end
    end
  endtask
  task automatic test_literal(input logic [DATA_W-1:0] w, input logic [13:0] v);
    logic [63:0] e = '0;
    for (int i = 0; i < L; i++) e[i] = v[L - 1 - i];
    @(negedge Clock);
    din = w;
    din_valid = 1'b1;
    test_frame(w, e, 0, '0);
  endtask
  task automatic test_random(input int n, input int mode);
    logic [DATA_W-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = DATA_W'($urandom);
      @(negedge Clock);
      din = w;
      din_valid = 1'b1;
      test_frame(w, model(w), mode, '0);
    end
  endtask
  task automatic test_back_to_back();
    logic [DATA_W-1:0] w;
    @(negedge Clock);
    din = 8'hFF;
    din_valid = 1'b1;
    for (int f = 0; f < 4; f++) begin
      w = (f % 2 == 1) ? 8'h00 : 8'hFF;
      test_frame(w, model(w), 2, ~w);
    end
    din_valid = 1'b0;
  endtask
  task automatic test_reset_mid();
    logic [DATA_W-1:0] w, w2;
    logic [63:0] e;
    logic [3:0] obs, want;
    w = DATA_W'($urandom);
    w2 = DATA_W'($urandom);
    e = model(w);
    @(negedge Clock);
    din = w;
    din_valid = 1'b1;
    @(posedge Clock);
    for (int i = 0; i < 7; i++) begin
      @(negedge Clock);
      din_valid = 1'b0;
      obs = {din_ready, sout_en, frame_done, sout};
      want = {3'b010, e[i]};
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL pre_reset bit %0d: got %b want %b", i, obs, want);
      end
      if (i == 6) Reset = 1'b1;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge Clock);
      Reset = 1'b0;
      obs = {din_ready, sout_en, frame_done, sout};
      checks++;
      if (obs !== 4'b1000) begin
        failures++;
        $display("FAIL post_reset cycle %0d: got %b want 1000", c, obs);
      end
    end
    din = w2;
    din_valid = 1'b1;
    test_frame(w2, model(w2), 0, '0);
  endtask
  initial begin
    test_reset();
    test_literal(8'hA5, P == 1 ? 14'b10010101001010 : 14'b01001010100101);
    test_literal(8'h01, P == 1 ? 14'b10010000000011 : 14'b01001000000001);
    test_random(6, 0);
    test_back_to_back();
    test_random(4, 1);
    test_reset_mid();
    test_random(2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
